// File: rtl/wshb_ram_slave_if.sv
// wshb_if: Wishbone B4 signal bundle between one master and one slave
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;
    modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte, input dat_sm, ack, err, rty);
    modport slave (input cyc, stb, we, adr, sel, dat_ms, cti, bte, output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_ram_slave.sv
// wshb_ram_slave: Wishbone B4 slave over on-chip word RAM with classic cycles and incrementing bursts
module wshb_ram_slave #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input logic   wshb_clk,
    input logic   wshb_rst_n,
    wshb_if.slave wshb_ifs
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CLASSIC_ACK, S_BURST} state_t;
    localparam logic [3:0] WAIT_M1 = 4'(WAIT > 0 ? WAIT - 1 : 0);
    logic [31:0]       mem [2**ADDR_W];
    state_t            state;
    state_t            ack_state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] in_word;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] wrap_m;
    logic [ADDR_W-1:0] rd_idx;
    logic [2:0]        cti_q;
    logic [2:0]        st_cti;
    logic [1:0]        bte_q;
    logic [31:0]       dat_q;
    logic [31:0]       rd_word;
    logic              we_q;
    logic              bad_q;
    logic              ack_r;
    logic              err_r;
    logic              in_bad;
    logic              st_bad;
    logic              go;
    logic              done;
    logic              wr;
    assign in_word   = wshb_ifs.adr[ADDR_W+1:2];
    assign in_bad    = (|wshb_ifs.adr[31:ADDR_W+2]) || (|wshb_ifs.adr[1:0]);
    assign st_bad    = (state == S_IDLE) ? in_bad : bad_q;
    assign st_cti    = (state == S_IDLE) ? wshb_ifs.cti : cti_q;
    assign ack_state = (st_cti == 3'b010 && !st_bad) ? S_BURST : S_CLASSIC_ACK;
    assign go        = (state == S_IDLE) ? (wshb_ifs.stb && WAIT == 0) : (state == S_WAIT && cnt == 4'd0);
    assign done      = ack_r && wshb_ifs.cyc && wshb_ifs.stb;
    assign wr        = done && we_q && (state == S_CLASSIC_ACK || state == S_BURST);
    // wrap bursts only advance the low log2(N) bits; linear advances the whole word index
    assign wrap_m    = (bte_q == 2'b01) ? ADDR_W'(3) : (bte_q == 2'b10) ? ADDR_W'(7) :
                       (bte_q == 2'b11) ? ADDR_W'(15) : '1;
    assign next_addr = (addr & ~wrap_m) | ((addr + ADDR_W'(1)) & wrap_m);
    // in a burst the next beat's word is fetched ahead so consecutive acks carry fresh data
    assign rd_idx    = (state == S_BURST) ? next_addr : (state == S_IDLE) ? in_word : addr;
    assign rd_word   = mem[rd_idx];
    assign wshb_ifs.ack    = ack_r && wshb_ifs.cyc && wshb_ifs.stb;
    assign wshb_ifs.err    = err_r && wshb_ifs.cyc && wshb_ifs.stb;
    assign wshb_ifs.dat_sm = dat_q;
    assign wshb_ifs.rty    = 1'b0;
    // Bus sequencer: latch the request, count wait states, then issue ack/err beats
    always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
        if (!wshb_rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            addr  <= '0;
            we_q  <= 1'b0;
            cti_q <= 3'b000;
            bte_q <= 2'b00;
            bad_q <= 1'b0;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_q <= '0;
        end else if (!wshb_ifs.cyc) begin
            state <= S_IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (wshb_ifs.stb) begin
                    addr  <= in_word;
                    we_q  <= wshb_ifs.we;
                    cti_q <= wshb_ifs.cti;
                    bte_q <= wshb_ifs.bte;
                    bad_q <= in_bad;
                    cnt   <= WAIT_M1;
                    state <= S_WAIT;
                end
                S_WAIT: cnt <= cnt - 4'd1;
                S_CLASSIC_ACK: begin
                    state <= S_IDLE;
                    ack_r <= 1'b0;
                    err_r <= 1'b0;
                    dat_q <= '0;
                end
                S_BURST: if (done) begin
                    if (wshb_ifs.cti == 3'b111) begin
                        state <= S_IDLE;
                        ack_r <= 1'b0;
                        dat_q <= '0;
                    end else begin
                        addr  <= next_addr;
                        dat_q <= rd_word;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (go) begin
                state <= ack_state;
                ack_r <= !st_bad;
                err_r <= st_bad;
                dat_q <= st_bad ? '0 : rd_word;
            end
        end
    end
    // RAM write port: commit the enabled byte lanes of each acknowledged write beat
    always_ff @(posedge wshb_clk) begin
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wshb_ifs.sel[i]) mem[addr][8*i +: 8] <= wshb_ifs.dat_ms[8*i +: 8];
            end
        end
    end
endmodule
